// File: rtl/multicycle_seq.sv
// Multi-cycle instruction sequencer for the RV32I subset datapath.
// Steps FETCH/DECODE/EXEC/MEM/WB, drives datapath strobes and counts retired instructions.
module multicycle_seq #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [31:0] ir,
    input  logic        br_taken,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        ir_load,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        rf_wen,
    output logic        pc_en,
    output logic        pc_sel,
    output logic        halted,
    output logic        fault,
    output logic [31:0] instret,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;
    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    // The request times out on the cycle whose miss brings the count to MEM_TIMEOUT.
    localparam logic [15:0] WAIT_LIMIT = 16'(MEM_TIMEOUT - 1);

    state_t      state_q;
    state_t      state_d;
    logic [15:0] wait_cnt;
    logic        waiting;
    logic        retire;
    logic        fault_set;
    logic [6:0]  opcode;
    logic        legal;
    logic        ir_unused;

    assign opcode    = ir[6:0];
    assign ir_unused = ^ir[31:7];
    assign legal     = (opcode == OP_LW) || (opcode == OP_SW) || (opcode == OP_R) ||
                       (opcode == OP_I)  || (opcode == OP_BR);
    assign state     = state_q;

    always_comb begin
        state_d   = state_q;
        ir_load   = 1'b0;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        rf_wen    = 1'b0;
        pc_en     = 1'b0;
        pc_sel    = 1'b0;
        halted    = 1'b0;
        retire    = 1'b0;
        fault_set = 1'b0;
        waiting   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_load = 1'b1;
                    state_d = S_DECODE;
                end else begin
                    waiting = 1'b1;
                    if (wait_cnt == WAIT_LIMIT) begin
                        state_d   = S_HALT;
                        fault_set = 1'b1;
                    end
                end
            end
            S_DECODE: begin
                state_d = legal ? S_EXEC : S_HALT;
            end
            S_EXEC: begin
                if (opcode == OP_BR) begin
                    pc_en  = 1'b1;
                    pc_sel = br_taken;
                    retire = 1'b1;
                end else if ((opcode == OP_LW) || (opcode == OP_SW)) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (opcode == OP_SW);
                if (dmem_ready) begin
                    if (opcode == OP_SW) begin
                        pc_en  = 1'b1;
                        retire = 1'b1;
                    end else begin
                        state_d = S_WB;
                    end
                end else begin
                    waiting = 1'b1;
                    if (wait_cnt == WAIT_LIMIT) begin
                        state_d   = S_HALT;
                        fault_set = 1'b1;
                    end
                end
            end
            S_WB: begin
                rf_wen = 1'b1;
                pc_en  = 1'b1;
                retire = 1'b1;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                halted    = 1'b1;
                state_d   = S_HALT;
                fault_set = 1'b1;
            end
        endcase
        if (retire) state_d = run ? S_FETCH : S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            wait_cnt <= 16'd0;
            fault    <= 1'b0;
            instret  <= 32'd0;
        end else begin
            state_q <= state_d;
            // Any state change clears the count, so FETCH and MEM always start from zero.
            if (state_d != state_q) wait_cnt <= 16'd0;
            else if (waiting)       wait_cnt <= wait_cnt + 16'd1;
            if (fault_set) fault   <= 1'b1;
            if (retire)    instret <= instret + 32'd1;
        end
    end

endmodule

// File: tb/tb_multicycle_seq.sv
// Directed bench for multicycle_seq: builds expected per-cycle traces from instruction
// class and memory wait counts, and compares every cycle against the DUT.
module tb_multicycle_seq;

    localparam int TMO = 4;

    localparam logic [7:0] IRL = 8'h80;
    localparam logic [7:0] IRQ = 8'h40;
    localparam logic [7:0] DRQ = 8'h20;
    localparam logic [7:0] DWE = 8'h10;
    localparam logic [7:0] RFW = 8'h08;
    localparam logic [7:0] PCE = 8'h04;
    localparam logic [7:0] PCS = 8'h02;
    localparam logic [7:0] HLT = 8'h01;

    localparam logic [31:0] I_ADD  = 32'h00208033;
    localparam logic [31:0] I_ADDI = 32'h00500093;
    localparam logic [31:0] I_LW   = 32'h0000A083;
    localparam logic [31:0] I_SW   = 32'h0020A023;
    localparam logic [31:0] I_BEQ  = 32'h00208063;
    localparam logic [31:0] I_BAD  = 32'h0000007F;

    logic        clk = 1'b0;
    logic        rst_n, run, br_taken, imem_ready, dmem_ready;
    logic [31:0] ir;
    logic        ir_load, imem_req, dmem_req, dmem_we, rf_wen, pc_en, pc_sel, halted, fault;
    logic [31:0] instret;
    logic [2:0]  state;

    multicycle_seq #(.MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .ir(ir), .br_taken(br_taken),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .ir_load(ir_load),
        .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we), .rf_wen(rf_wen),
        .pc_en(pc_en), .pc_sel(pc_sel), .halted(halted), .fault(fault),
        .instret(instret), .state(state)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          dreq_cnt = 0;
    int          ireq_cnt = 0;
    logic [43:0] exp_q[$];
    string       name_q[$];
    logic [31:0] m_instret = 32'd0;
    logic        m_fault = 1'b0;

    function automatic logic [43:0] ex(input logic [2:0] st, input logic [7:0] f);
        return {st, f, m_fault, m_instret};
    endfunction

    // Sole compare point for the traced outputs; runs mid-cycle, away from the active edge.
    always @(negedge clk) begin
        logic [43:0] act;
        logic [43:0] e;
        string       nm;
        act = {state, ir_load, imem_req, dmem_req, dmem_we, rf_wen, pc_en, pc_sel,
               halted, fault, instret};
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL %s: got %h expected %h (state,strobes,fault,instret)", nm, act, e);
            end
        end
        if (dmem_req === 1'b1) dreq_cnt++;
        if (imem_req === 1'b1) ireq_cnt++;
    end

    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    task automatic cyc(input string nm, input logic [43:0] e, input logic r,
                       input logic irdy, input logic drdy);
        run        = r;
        imem_ready = irdy;
        dmem_ready = drdy;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        run = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        @(posedge clk);
        #1;
        m_instret = 32'd0;
        m_fault   = 1'b0;
        cyc("reset", ex(3'd0, 8'h00), 1'b1, 1'b1, 1'b1);
        rst_n = 1'b1;
    endtask

    task automatic idle(input int n, input logic r);
        for (int k = 0; k < n; k++) cyc("idle", ex(3'd0, 8'h00), r, 1'b1, 1'b1);
    endtask

    task automatic halt_cyc(input int n);
        for (int k = 0; k < n; k++) cyc("halt", ex(3'd6, HLT), 1'b1, 1'b1, 1'b1);
    endtask

    // Whole instruction from FETCH entry; iw/dw are miss cycles before ready.
    task automatic do_instr(input logic [31:0] instr, input int iw, input int dw,
                            input logic br, input logic run_end);
        logic [6:0] op;
        logic       is_sw, is_mem, last;
        op       = instr[6:0];
        is_sw    = (op == 7'b0100011);
        is_mem   = is_sw || (op == 7'b0000011);
        ir       = instr;
        br_taken = br;
        for (int k = 0; k <= iw; k++)
            cyc("fetch", ex(3'd1, IRQ | ((k == iw) ? IRL : 8'h00)), 1'b1, k == iw, 1'b1);
        cyc("decode", ex(3'd2, 8'h00), 1'b1, 1'b1, 1'b1);
        if (!(is_mem || op == 7'b0110011 || op == 7'b0010011 || op == 7'b1100011)) return;
        if (op == 7'b1100011) begin
            cyc("exec_branch", ex(3'd3, PCE | (br ? PCS : 8'h00)), run_end, 1'b1, 1'b1);
            m_instret++;
            return;
        end
        cyc("exec", ex(3'd3, 8'h00), run_end, 1'b1, 1'b1);
        if (is_mem) begin
            for (int k = 0; k <= dw; k++) begin
                last = (k == dw);
                cyc("mem", ex(3'd4, DRQ | (is_sw ? DWE : 8'h00) | ((is_sw && last) ? PCE : 8'h00)),
                    run_end, 1'b1, last);
            end
            if (is_sw) begin
                m_instret++;
                return;
            end
        end
        cyc("wb", ex(3'd5, RFW | PCE), run_end, 1'b1, 1'b1);
        m_instret++;
    endtask

    initial begin
        int snap;
        ir = 32'd0; br_taken = 1'b0;
        do_reset();

        idle(1, 1'b1);
        do_instr(I_ADD, 0, 0, 1'b0, 1'b1);
        lit("instret_after_add", instret, 32'd1);
        do_instr(I_ADDI, 2, 0, 1'b0, 1'b1);

        snap = dreq_cnt;
        do_instr(I_LW, 0, 3, 1'b0, 1'b1);
        lit("lw_dmem_req_cycles", 32'(dreq_cnt - snap), 32'd4);

        do_instr(I_BEQ, 0, 0, 1'b1, 1'b1);
        do_instr(I_BEQ, 1, 0, 1'b0, 1'b1);
        do_instr(I_SW, 1, 2, 1'b0, 1'b0);
        snap = ireq_cnt;
        idle(3, 1'b0);
        lit("no_fetch_after_run_drop", 32'(ireq_cnt - snap), 32'd0);
        lit("instret_before_reset", instret, 32'd6);

        idle(1, 1'b1);
        ir = I_SW;
        cyc("fetch", ex(3'd1, IRQ | IRL), 1'b1, 1'b1, 1'b1);
        cyc("decode", ex(3'd2, 8'h00), 1'b1, 1'b1, 1'b1);
        cyc("exec", ex(3'd3, 8'h00), 1'b1, 1'b1, 1'b1);
        cyc("mem_wait", ex(3'd4, DRQ | DWE), 1'b1, 1'b1, 1'b0);
        rst_n = 1'b0;
        cyc("mem_at_reset", ex(3'd4, DRQ | DWE), 1'b1, 1'b1, 1'b0);
        m_instret = 32'd0;
        m_fault   = 1'b0;
        cyc("after_reset", ex(3'd0, 8'h00), 1'b1, 1'b1, 1'b1);
        rst_n = 1'b1;
        lit("instret_after_reset", instret, 32'd0);

        force dut.instret = 32'hFFFF_FFFF;
        #1;
        release dut.instret;
        m_instret = 32'hFFFF_FFFF;
        idle(1, 1'b1);
        do_instr(I_ADD, 0, 0, 1'b0, 1'b0);
        lit("instret_wrap", instret, 32'd0);
        idle(1, 1'b0);

        idle(1, 1'b1);
        ir = I_LW;
        cyc("fetch", ex(3'd1, IRQ | IRL), 1'b1, 1'b1, 1'b1);
        cyc("decode", ex(3'd2, 8'h00), 1'b1, 1'b1, 1'b1);
        cyc("exec", ex(3'd3, 8'h00), 1'b1, 1'b1, 1'b1);
        snap = dreq_cnt;
        for (int k = 0; k < TMO; k++) cyc("mem_timeout", ex(3'd4, DRQ), 1'b1, 1'b1, 1'b0);
        m_fault = 1'b1;
        halt_cyc(3);
        lit("dmem_timeout_req_cycles", 32'(dreq_cnt - snap), 32'd4);
        do_reset();

        idle(1, 1'b1);
        do_instr(I_BAD, 0, 0, 1'b0, 1'b1);
        halt_cyc(20);
        lit("illegal_fault", {31'd0, fault}, 32'd0);
        do_reset();

        idle(1, 1'b1);
        ir = I_ADD;
        snap = ireq_cnt;
        for (int k = 0; k < TMO; k++) cyc("fetch_timeout", ex(3'd1, IRQ), 1'b1, 1'b0, 1'b1);
        m_fault = 1'b1;
        halt_cyc(3);
        lit("imem_timeout_req_cycles", 32'(ireq_cnt - snap), 32'd4);
        lit("timeout_halted", {31'd0, halted}, 32'd1);
        lit("timeout_fault", {31'd0, fault}, 32'd1);

        lit("trace_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
